mem_wb_pipe: RTL and testbench

- Parametrised successor to the single-stage MEM→WB pipeline latch.
- Carries ALU result, memory output, m2reg, wreg and destination register number through DEPTH register stages.
- Adds per-stage valid, stall (hold), flush (bubble insertion), a muxed writeback-data output, and a combinational forwarding lookup over all in-flight stages.
- Sits between the data-memory stage and the register-file write port. The hazard unit drives stall/flush and consumes the forwarding outputs.

---
 rtl/mem_wb_pipe.sv | 129 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// ============================================================================
// Module   : mem_wb_pipe
// Brief    : DEPTH-stage MEM->WB pipeline with valid, stall, flush, a muxed
//            writeback data output and a forwarding lookup over all stages.
//            Optional stall counter enabled by macro MEM_WB_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int RN_W   = 5,
    parameter int DEPTH  = 1      // legal range 1..4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_Alu_Result,
    input  logic [DATA_W-1:0] mem_mo,
    input  logic              mem_m2reg,
    input  logic              mem_wreg,
    input  logic [RN_W-1:0]   mem_rn,
    input  logic              stall,
    input  logic              flush,
    input  logic [RN_W-1:0]   fwd_rn,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_Alu_Result,
    output logic [DATA_W-1:0] wb_mo,
    output logic              wb_m2reg,
    output logic              wb_wreg,
    output logic [RN_W-1:0]   wb_rn,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mo;
        logic              m2reg;
        logic              wreg;
        logic [RN_W-1:0]   rn;
    } stage_t;

    // Forwarding priority chain: index k resolves stages k..DEPTH-1, so
    // index 0 carries the youngest match.
    logic [DEPTH:0]             hit_chain;
    logic [DEPTH:0][DATA_W-1:0] data_chain;

    assign hit_chain[DEPTH]  = 1'b0;
    assign data_chain[DEPTH] = '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        stage_t stage_q;
        stage_t stage_d;
        logic   match;

        if (k == 0) begin : g_head
            always_comb begin
                stage_d = stage_q;
                if (flush) begin
                    stage_d = '0;
                end else if (!stall) begin
                    stage_d.valid = mem_valid;
                    stage_d.alu   = mem_Alu_Result;
                    stage_d.mo    = mem_mo;
                    stage_d.m2reg = mem_m2reg;
                    stage_d.wreg  = mem_wreg & mem_valid;
                    stage_d.rn    = mem_rn;
                end
            end
        end else begin : g_body
            always_comb begin
                stage_d = stage_q;
                if (!stall) begin
                    stage_d = g_stage[k-1].stage_q;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign match = stage_q.valid && stage_q.wreg &&
                       (stage_q.rn == fwd_rn) && (fwd_rn != '0);
        assign hit_chain[k]  = match | hit_chain[k+1];
        assign data_chain[k] = match ? (stage_q.m2reg ? stage_q.mo : stage_q.alu)
                                     : data_chain[k+1];
    end

    assign wb_valid      = g_stage[DEPTH-1].stage_q.valid;
    assign wb_Alu_Result = g_stage[DEPTH-1].stage_q.alu;
    assign wb_mo         = g_stage[DEPTH-1].stage_q.mo;
    assign wb_m2reg      = g_stage[DEPTH-1].stage_q.m2reg;
    assign wb_wreg       = g_stage[DEPTH-1].stage_q.wreg;
    assign wb_rn         = g_stage[DEPTH-1].stage_q.rn;
    assign wb_data       = wb_m2reg ? wb_mo : wb_Alu_Result;

    assign fwd_hit  = hit_chain[0];
    assign fwd_data = data_chain[0];

`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stalled edges; flush has no effect.
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
// ============================================================================
// Module   : tb_mem_wb_pipe
// Brief    : Directed self-checking bench for mem_wb_pipe at DEPTH 1, 2 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        clr;
    logic        mem_valid;
    logic [31:0] mem_Alu_Result;
    logic [31:0] mem_mo;
    logic        mem_m2reg;
    logic        mem_wreg;
    logic [4:0]  mem_rn;
    logic        stall;
    logic        flush;
    logic [4:0]  fwd_rn;

    logic        wb_valid   [3];
    logic [31:0] wb_alu     [3];
    logic [31:0] wb_mo      [3];
    logic        wb_m2reg   [3];
    logic        wb_wreg    [3];
    logic [4:0]  wb_rn      [3];
    logic [31:0] wb_data    [3];
    logic        fwd_hit    [3];
    logic [31:0] fwd_data   [3];
`ifdef MEM_WB_STALL_CNT_EN
    logic [15:0] stall_cnt  [3];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        mem_wb_pipe #(.DATA_W(32), .RN_W(5), .DEPTH(d + 1)) u_dut (
            .clk            (clk),
            .clr            (clr),
            .mem_valid      (mem_valid),
            .mem_Alu_Result (mem_Alu_Result),
            .mem_mo         (mem_mo),
            .mem_m2reg      (mem_m2reg),
            .mem_wreg       (mem_wreg),
            .mem_rn         (mem_rn),
            .stall          (stall),
            .flush          (flush),
            .fwd_rn         (fwd_rn),
            .wb_valid       (wb_valid[d]),
            .wb_Alu_Result  (wb_alu[d]),
            .wb_mo          (wb_mo[d]),
            .wb_m2reg       (wb_m2reg[d]),
            .wb_wreg        (wb_wreg[d]),
            .wb_rn          (wb_rn[d]),
            .wb_data        (wb_data[d]),
            .fwd_hit        (fwd_hit[d]),
            .fwd_data       (fwd_data[d])
`ifdef MEM_WB_STALL_CNT_EN
            ,
            .stall_cnt      (stall_cnt[d])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mo,
                         input logic m2, input logic wr, input logic [4:0] rn);
        mem_valid      = v;
        mem_Alu_Result = alu;
        mem_mo         = mo;
        mem_m2reg      = m2;
        mem_wreg       = wr;
        mem_rn         = rn;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b0; stall = 1'b0; flush = 1'b0; fwd_rn = 5'd0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);

        // Reset state
        do_reset();
        check("rst_d1_valid",  {31'b0, wb_valid[0]}, 32'd0);
        check("rst_d1_data",   wb_data[0], 32'd0);
        check("rst_d3_rn",     {27'b0, wb_rn[2]}, 32'd0);
        check("rst_d2_wreg",   {31'b0, wb_wreg[1]}, 32'd0);
        fwd_rn = 5'd0; #1;
        check("rst_d1_fwdhit", {31'b0, fwd_hit[0]}, 32'd0);

        // DEPTH=1 single-cycle latency
        drive(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b1, 5'd5);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        check("d1_wb_data",  wb_data[0], 32'h0000_1234);
        check("d1_wb_wreg",  {31'b0, wb_wreg[0]}, 32'd1);
        check("d1_wb_rn",    {27'b0, wb_rn[0]}, 32'd5);
        check("d1_wb_valid", {31'b0, wb_valid[0]}, 32'd1);
        fwd_rn = 5'd5; #1;
        check("d1_fwd_hit",  {31'b0, fwd_hit[0]}, 32'd1);
        check("d1_fwd_data", fwd_data[0], 32'h0000_1234);

        // DEPTH=3 ordering across a 2-cycle stall
        do_reset();
        drive(1'b1, 32'h11, 32'h0, 1'b0, 1'b1, 5'd1); tick();
        drive(1'b1, 32'h22, 32'h0, 1'b0, 1'b1, 5'd2); tick();
        drive(1'b1, 32'h33, 32'h0, 1'b0, 1'b1, 5'd3); tick();
        check("d3_lat_rn",   {27'b0, wb_rn[2]}, 32'd1);
        check("d3_lat_data", wb_data[2], 32'h11);
        drive(1'b1, 32'h99, 32'h0, 1'b0, 1'b1, 5'd9);
        stall = 1'b1;
        tick();
        check("d3_stall1_rn", {27'b0, wb_rn[2]}, 32'd1);
        tick();
        check("d3_stall2_rn", {27'b0, wb_rn[2]}, 32'd1);
`ifdef MEM_WB_STALL_CNT_EN
        check("d3_stall_cnt", {16'b0, stall_cnt[2]}, 32'd2);
`endif
        stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        tick();
        check("d3_resume_rn2", {27'b0, wb_rn[2]}, 32'd2);
        tick();
        check("d3_resume_rn3", {27'b0, wb_rn[2]}, 32'd3);
        tick();
        check("d3_drain_valid", {31'b0, wb_valid[2]}, 32'd0);
        check("d3_drain_rn",    {27'b0, wb_rn[2]}, 32'd0);

        // DEPTH=2 flush turns the incoming instruction into a bubble
        do_reset();
        drive(1'b1, 32'h77, 32'h0, 1'b0, 1'b1, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        fwd_rn = 5'd7; #1;
        check("d2_flush_fwdhit", {31'b0, fwd_hit[1]}, 32'd0);
        tick();
        check("d2_flush_wreg",  {31'b0, wb_wreg[1]}, 32'd0);
        check("d2_flush_valid", {31'b0, wb_valid[1]}, 32'd0);

        // DEPTH=2 forwarding: youngest match wins
        do_reset();
        drive(1'b1, 32'hAA, 32'h0, 1'b0, 1'b1, 5'd4); tick();
        drive(1'b1, 32'hCC, 32'hBB, 1'b1, 1'b1, 5'd4); tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        fwd_rn = 5'd4; #1;
        check("d2_fwd_hit",   {31'b0, fwd_hit[1]}, 32'd1);
        check("d2_fwd_data",  fwd_data[1], 32'hBB);
        check("d2_wb_data",   wb_data[1], 32'hAA);
        fwd_rn = 5'd0; #1;
        check("d2_fwd0_hit",  {31'b0, fwd_hit[1]}, 32'd0);
        check("d2_fwd0_data", fwd_data[1], 32'd0);

        // flush+stall: stage 0 bubbles, stage 1 holds
        drive(1'b1, 32'h55, 32'h0, 1'b0, 1'b1, 5'd6);
        flush = 1'b1; stall = 1'b1;
        tick();
        check("d2_fs_rn",   {27'b0, wb_rn[1]}, 32'd4);
        check("d2_fs_data", wb_data[1], 32'hAA);
        fwd_rn = 5'd4; #1;
        check("d2_fs_fwd",  fwd_data[1], 32'hAA);
        // flush alone: stage 1 advances the bubble out of stage 0
        stall = 1'b0;
        tick();
        flush = 1'b0;
        check("d2_f_valid", {31'b0, wb_valid[1]}, 32'd0);
        check("d2_f_hit",   {31'b0, fwd_hit[1]}, 32'd0);

        // clr wins over a stall with every stage valid
        drive(1'b1, 32'h101, 32'h0, 1'b0, 1'b1, 5'd1); tick();
        drive(1'b1, 32'h102, 32'h0, 1'b0, 1'b1, 5'd2); tick();
        drive(1'b1, 32'h103, 32'h0, 1'b0, 1'b1, 5'd3); tick();
        check("pre_clr_valid", {31'b0, wb_valid[2]}, 32'd1);
        stall = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
        fwd_rn = 5'd1; #1;
        check("clr_d3_valid", {31'b0, wb_valid[2]}, 32'd0);
        check("clr_d3_rn",    {27'b0, wb_rn[2]}, 32'd0);
        check("clr_d3_data",  wb_data[2], 32'd0);
        check("clr_d3_fwd",   {31'b0, fwd_hit[2]}, 32'd0);
        check("clr_d2_wreg",  {31'b0, wb_wreg[1]}, 32'd0);
`ifdef MEM_WB_STALL_CNT_EN
        check("clr_stall_cnt", {16'b0, stall_cnt[2]}, 32'd0);

        // Counter saturation
        stall = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        stall = 1'b0;
        check("sat_stall_cnt", {16'b0, stall_cnt[0]}, 32'h0000_FFFF);
        tick();
        check("sat_hold_cnt",  {16'b0, stall_cnt[0]}, 32'h0000_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
